// File: rtl/mux_2x1_arbiter_pkg.sv
// mux_2x1_arbiter_pkg: shared state and select encodings for the two-requester arbiter
package mux_2x1_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;
  localparam int   WIDTH_DEF = 32;
  localparam logic SEL_I0    = 1'b0;
  localparam logic SEL_I1    = 1'b1;
endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: two-input word multiplexer, S=0 picks I0, S=1 picks I1
module mux_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);
  assign Y = S ? I1 : I0;
endmodule

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: round-robin arbiter sharing one mux_2x1 between two requesters and a sink
module mux_2x1_arbiter
  import mux_2x1_arbiter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             sink_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);
  state_t           state, nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] y;
  logic             xfer, at_max, enter;
  mux_2x1 #(.WIDTH(WIDTH)) u_mux (.Y(y), .S(sel), .I0(din0), .I1(din1));
  assign gnt0 = state == G0;
  assign gnt1 = state == G1;
  always_comb begin
    xfer   = ((state == G0 && req0) || (state == G1 && req1)) && sink_ready;
    at_max = cnt == CNT_W'(MAX_HOLD - 1);
    nxt    = state;
    case (state)
      IDLE:    nxt = (req0 && req1) ? (last ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
      G0:      nxt = !req0 ? (req1 ? G1 : IDLE) : (xfer && at_max && req1) ? G1 : G0;
      G1:      nxt = !req1 ? (req0 ? G0 : IDLE) : (xfer && at_max && req0) ? G0 : G1;
      default: nxt = IDLE;
    endcase
    enter  = nxt != state && nxt != IDLE;
  end
  // a solo requester at the hold limit keeps its grant; only its tenure count restarts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= SEL_I0;
      last       <= 1'b1;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= nxt;
      dout_valid <= xfer;
      if (xfer) dout <= y;
      if (enter) begin
        last <= nxt == G1;
        sel  <= (nxt == G1) ? SEL_I1 : SEL_I0;
        cnt  <= '0;
      end else if (xfer) begin
        cnt  <= at_max ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb_mux_2x1_arbiter: directed and random checks against a tenure-level arbitration model
module tb_mux_2x1_arbiter;
  localparam int MAX_HOLD = 4;
  logic        clk = 0;
  logic        reset, req0, req1, sink_ready;
  logic [31:0] din0, din1;
  logic        gnt0, gnt1, sel, dout_valid;
  logic [31:0] dout;
  int          cmp = 0, errs = 0;
  int          own, last, n, src;
  logic        m_sel, m_v;
  logic [31:0] m_dout;
  logic [31:0] exp_k;
  mux_2x1_arbiter #(.WIDTH(32), .MAX_HOLD(MAX_HOLD), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .sink_ready(sink_ready), .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .dout(dout),
    .dout_valid(dout_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all();
    chk("gnt0", {31'b0, gnt0}, {31'b0, own == 1});
    chk("gnt1", {31'b0, gnt1}, {31'b0, own == 2});
    chk("sel", {31'b0, sel}, {31'b0, m_sel});
    chk("dout_valid", {31'b0, dout_valid}, {31'b0, m_v});
    chk("dout", dout, m_dout);
  endtask
  task automatic model_reset();
    own = 0; last = 1; n = 0; m_sel = 0; m_v = 0; m_dout = 0; src = 0;
  endtask
  // owner 0 = nobody, 1 = requester 0, 2 = requester 1; n counts transfers in this tenure
  task automatic model_step();
    bit mine, other, x;
    int no;
    mine  = (own == 1) ? req0 : req1;
    other = (own == 1) ? req1 : req0;
    x     = own != 0 && mine && sink_ready;
    m_v   = x;
    src   = x ? own : 0;
    if (x) m_dout = (own == 1) ? din0 : din1;
    no = own;
    if (own == 0) no = (req0 && req1) ? ((last == 1) ? 1 : 2) : req0 ? 1 : req1 ? 2 : 0;
    else if (!mine) no = other ? 3 - own : 0;
    else if (x) begin
      n++;
      if (n == MAX_HOLD) begin
        if (other) no = 3 - own;
        else n = 0;
      end
    end
    if (no != own && no != 0) begin
      last = no - 1; n = 0; m_sel = logic'(no - 1);
    end
    own = no;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 check_all();
    if (src == 1) din0 = din0 + 1;
    if (src == 2) din1 = din1 - 1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    reset = 0;
  endtask
  initial begin
    reset = 1; req0 = 0; req1 = 0; sink_ready = 0; din0 = 0; din1 = 0;
    model_reset();
    #12 check_all();
    @(posedge clk);
    #1 reset = 0;
    req0 = 1; din0 = 32'h1; sink_ready = 1; exp_k = 1;
    repeat (12) begin
      cyc();
      if (m_v) begin
        chk("solo_seq", dout, exp_k);
        exp_k++;
      end
    end
    do_reset();
    req0 = 1; req1 = 1; din0 = 32'h100; din1 = 32'hFFFF_FFFF;
    repeat (12) cyc();
    for (int i = 0; i < 20 && own != 2; i++) cyc();
    chk("in_g1", {31'b0, gnt1}, 32'd1);
    cyc();
    sink_ready = 0;
    repeat (3) cyc();
    sink_ready = 1;
    repeat (6) cyc();
    do_reset();
    req0 = 1; req1 = 1;
    repeat (3) cyc();
    req0 = 0;
    repeat (3) cyc();
    do_reset();
    req0 = 1; req1 = 0;
    repeat (3) cyc();
    req0 = 0;
    repeat (3) cyc();
    chk("idle_sel", {31'b0, sel}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      sink_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) begin
        din0 = $urandom;
        din1 = $urandom;
      end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
